// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pkg
//  Description : Shared state encoding, 50 MHz default timing and parameter
//                sanity check for the WS2812 chain transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    // Transmitter FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_FETCH = 2'd1;
    localparam state_t c_ST_SEND  = 2'd2;
    localparam state_t c_ST_LATCH = 2'd3;

    // One GRB word per LED
    localparam int c_BITS_PER_PIX = 24;

    // Default timing for a 50 MHz clock
    localparam int c_DEF_BIT_CYC   = 63;     // 1.25 us bit period
    localparam int c_DEF_T0H_CYC   = 20;     // 0.40 us high for a 0 bit
    localparam int c_DEF_T1H_CYC   = 40;     // 0.80 us high for a 1 bit
    localparam int c_DEF_RESET_CYC = 14000;  // 280 us latch gap

    // True when the timing parameter set describes a usable waveform
    function automatic bit ws2812_timing_ok(input int n_leds, input int bit_cyc,
                                            input int t0h_cyc, input int t1h_cyc,
                                            input int reset_cyc);
        return (n_leds >= 1) && (t0h_cyc >= 1) && (t0h_cyc < t1h_cyc) &&
               (t1h_cyc < bit_cyc) && (reset_cyc >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_bit_timer
//  Description : Per-bit cycle counter and pulse-width comparator. Produces
//                the line level for the current bit and flags its last cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int BIT_CYC = c_DEF_BIT_CYC,
    parameter int T0H_CYC = c_DEF_T0H_CYC,
    parameter int T1H_CYC = c_DEF_T1H_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic bit_i,
    output logic level_o,
    output logic bit_last_o
);

    localparam int c_CNT_W = $clog2(BIT_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_T0H      = c_CNT_W'(T0H_CYC);
    localparam logic [c_CNT_W-1:0] c_T1H      = c_CNT_W'(T1H_CYC);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    assign bit_last_o = en_i && (cnt_q == c_CNT_LAST);
    assign level_o    = en_i && (cnt_q < (bit_i ? c_T1H : c_T0H));

    // Count through the bit period while enabled; park at zero otherwise
    always_comb begin
        cnt_d = '0;
        if (en_i && !bit_last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Bit counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ws2812_chain_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_chain_tx
//  Description : Frame transmitter for a chain of WS2812-class LEDs. Fetches
//                one GRB word per LED, serialises MSB-first as pulse-width
//                coded bits, then holds the line low for the latch gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_chain_tx
    import ws2812_pkg::*;
#(
    parameter int N_LEDS    = 8,
    parameter int BIT_CYC   = c_DEF_BIT_CYC,
    parameter int T0H_CYC   = c_DEF_T0H_CYC,
    parameter int T1H_CYC   = c_DEF_T1H_CYC,
    parameter int RESET_CYC = c_DEF_RESET_CYC,
    parameter int IDX_W     = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             auto_repeat_i,
    output logic             pix_rd_o,
    output logic [IDX_W-1:0] pix_idx_o,
    input  logic [23:0]      pix_data_i,
    output logic             dout_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int c_BIT_IDX_W = $clog2(c_BITS_PER_PIX);
    localparam int c_LAT_W     = $clog2(RESET_CYC + 1);
    localparam logic [c_BIT_IDX_W-1:0] c_BIT_IDX_LAST = c_BIT_IDX_W'(c_BITS_PER_PIX - 1);
    localparam logic [IDX_W-1:0]       c_PIX_LAST     = IDX_W'(N_LEDS - 1);
    localparam logic [c_LAT_W-1:0]     c_LAT_END      = c_LAT_W'(RESET_CYC);

    generate
        if (!ws2812_timing_ok(N_LEDS, BIT_CYC, T0H_CYC, T1H_CYC, RESET_CYC)) begin : g_bad_timing
            $error("ws2812_chain_tx: inconsistent timing parameters");
        end
    endgenerate

    state_t                 state_q,    state_d;
    logic                   fetch_ph_q, fetch_ph_d;  // 0: strobe cycle, 1: data cycle
    logic [c_BIT_IDX_W-1:0] bitn_q,     bitn_d;
    logic [IDX_W-1:0]       pix_q,      pix_d;
    logic [c_LAT_W-1:0]     lat_q,      lat_d;
    logic [23:0]            shift_q,    shift_d;
    logic [23:0]            hold_q,     hold_d;
    logic                   pfirst_q,   pfirst_d;    // first cycle of a pixel
    logic                   pre_vld_q,  pre_vld_d;   // prefetched word on pix_data_i

    logic w_send;
    logic w_level;
    logic w_bit_last;
    logic w_prefetch;
    logic w_lat_end;

    assign w_send     = (state_q == c_ST_SEND);
    assign w_prefetch = pfirst_q && (pix_q != c_PIX_LAST);
    // The last LATCH count is the done cycle itself
    assign w_lat_end  = (state_q == c_ST_LATCH) && (lat_q == c_LAT_END);

    ws2812_bit_timer #(
        .BIT_CYC (BIT_CYC),
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .en_i       (w_send),
        .bit_i      (shift_q[23]),
        .level_o    (w_level),
        .bit_last_o (w_bit_last)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_ST_IDLE;
            fetch_ph_q <= 1'b0;
            bitn_q     <= '0;
            pix_q      <= '0;
            lat_q      <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            pfirst_q   <= 1'b0;
            pre_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_ph_q <= fetch_ph_d;
            bitn_q     <= bitn_d;
            pix_q      <= pix_d;
            lat_q      <= lat_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            pfirst_q   <= pfirst_d;
            pre_vld_q  <= pre_vld_d;
        end
    end

    // Next-state and counter/shift logic
    always_comb begin
        state_d    = state_q;
        fetch_ph_d = fetch_ph_q;
        bitn_d     = bitn_q;
        pix_d      = pix_q;
        lat_d      = lat_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        pfirst_d   = 1'b0;
        pre_vld_d  = w_prefetch;
        case (state_q)
            c_ST_IDLE: begin
                if (start_i) begin
                    state_d    = c_ST_FETCH;
                    fetch_ph_d = 1'b0;
                end
            end
            c_ST_FETCH: begin
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    fetch_ph_d = 1'b0;
                    shift_d    = pix_data_i;
                    bitn_d     = '0;
                    pix_d      = '0;
                    pfirst_d   = 1'b1;
                    state_d    = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                if (pre_vld_q) begin
                    hold_d = pix_data_i;
                end
                if (w_bit_last) begin
                    if (bitn_q == c_BIT_IDX_LAST) begin
                        bitn_d = '0;
                        if (pix_q == c_PIX_LAST) begin
                            pix_d   = '0;
                            lat_d   = '0;
                            state_d = c_ST_LATCH;
                        end else begin
                            pix_d    = pix_q + 1'b1;
                            shift_d  = hold_q;
                            pfirst_d = 1'b1;
                        end
                    end else begin
                        bitn_d  = bitn_q + 1'b1;
                        shift_d = shift_q << 1;
                    end
                end
            end
            default: begin  // c_ST_LATCH
                if (w_lat_end) begin
                    lat_d = '0;
                    if (auto_repeat_i) begin
                        // This cycle already issued the index-0 strobe
                        state_d    = c_ST_FETCH;
                        fetch_ph_d = 1'b1;
                    end else begin
                        state_d = c_ST_IDLE;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
        endcase
    end

    // Output decode
    always_comb begin
        pix_rd_o  = ((state_q == c_ST_FETCH) && !fetch_ph_q) || w_prefetch ||
                    (w_lat_end && auto_repeat_i);
        pix_idx_o = w_prefetch ? (pix_q + 1'b1) : '0;
        busy_o    = (state_q != c_ST_IDLE) && !(w_lat_end && !auto_repeat_i);
        done_o    = w_lat_end;
        dout_o    = w_level;
    end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_chain_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_chain_tx
//  Description : Directed self-checking bench for ws2812_chain_tx, with a
//                two-LED instance and a one-LED instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_chain_tx;

    localparam int BIT = 10;
    localparam int RC  = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, start1, ar0, ar1;
    logic        rd0, rd1;
    logic [0:0]  idx0, idx1;
    logic [23:0] pd0, pd1;
    logic        dout0, dout1, busy0, busy1, done0, done1;

    logic [23:0] mem0 [2];
    logic [23:0] mem1;

    int errors = 0;
    int total  = 0;
    logic sel = 1'b0;

    // Fixed-latency pixel stores: word valid the cycle after the strobe
    always @(posedge clk) pd0 <= rd0 ? mem0[idx0] : 24'hxxxxxx;
    always @(posedge clk) pd1 <= rd1 ? mem1       : 24'hxxxxxx;

    ws2812_chain_tx #(.N_LEDS(2), .BIT_CYC(10), .T0H_CYC(3), .T1H_CYC(7), .RESET_CYC(20)) u_dut2 (
        .clk(clk), .rst(rst), .start_i(start0), .auto_repeat_i(ar0),
        .pix_rd_o(rd0), .pix_idx_o(idx0), .pix_data_i(pd0),
        .dout_o(dout0), .busy_o(busy0), .done_o(done0));

    ws2812_chain_tx #(.N_LEDS(1), .BIT_CYC(10), .T0H_CYC(3), .T1H_CYC(7), .RESET_CYC(20)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .auto_repeat_i(ar1),
        .pix_rd_o(rd1), .pix_idx_o(idx1), .pix_data_i(pd1),
        .dout_o(dout1), .busy_o(busy1), .done_o(done1));

    logic w_dout, w_busy, w_done, w_rd;
    logic [0:0] w_idx;
    assign w_dout = sel ? dout1 : dout0;
    assign w_busy = sel ? busy1 : busy0;
    assign w_done = sel ? done1 : done0;
    assign w_rd   = sel ? rd1   : rd0;
    assign w_idx  = sel ? idx1  : idx0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit v);
        start0 = sel ? 1'b0 : v;
        start1 = sel ? v : 1'b0;
    endtask

    task automatic set_ar(input bit v);
        ar0 = sel ? 1'b0 : v;
        ar1 = sel ? v : 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered in the strobe cycle (c1); returns in the done cycle
    task automatic frame(input string tag, input logic [23:0] p0, input logic [23:0] p1,
                         input int n, input bit ar, input bit poke);
        logic [15:0] pat;
        logic [15:0] exp_pat;
        logic [23:0] px;
        int rd_cnt, bl, dn, hi, lr;
        chk($sformatf("%s c1 busy", tag), w_busy, 1);
        chk($sformatf("%s c1 pix_rd", tag), w_rd, 1);
        chk($sformatf("%s c1 pix_idx", tag), w_idx, 0);
        tick();
        set_ar(ar);
        set_start(poke);
        tick();
        rd_cnt = 0; bl = 0; dn = 0; hi = 0; lr = 0;
        for (int b = 0; b < 24 * n; b++) begin
            pat = '0;
            for (int j = 0; j < BIT; j++) begin
                if (b == 0 && j == 0) begin
                    chk($sformatf("%s c3 pix_rd", tag), w_rd, (n > 1) ? 1 : 0);
                    chk($sformatf("%s c3 pix_idx", tag), w_idx, (n > 1) ? 1 : 0);
                end
                pat[j] = w_dout;
                if (w_rd)    rd_cnt++;
                if (!w_busy) bl++;
                if (w_done)  dn++;
                set_start(poke && (j == 0) && (b % 3 == 0));
                tick();
            end
            px      = (b < 24) ? p0 : p1;
            exp_pat = px[23 - (b % 24)] ? 16'h007F : 16'h0007;
            chk($sformatf("%s bit%0d", tag, b), pat, exp_pat);
        end
        chk($sformatf("%s send pix_rd count", tag), rd_cnt, (n > 1) ? 1 : 0);
        for (int c = 0; c < RC; c++) begin
            if (w_dout)  hi++;
            if (w_done)  dn++;
            if (!w_busy) bl++;
            if (w_rd)    lr++;
            set_start(poke && (c % 4 == 1));
            tick();
        end
        set_start(1'b0);
        chk($sformatf("%s latch dout high", tag), hi, 0);
        chk($sformatf("%s latch pix_rd", tag), lr, 0);
        chk($sformatf("%s early done", tag), dn, 0);
        chk($sformatf("%s busy drop", tag), bl, 0);
        chk($sformatf("%s done", tag), w_done, 1);
        chk($sformatf("%s done busy", tag), w_busy, ar);
        chk($sformatf("%s done pix_rd", tag), w_rd, ar);
        chk($sformatf("%s done pix_idx", tag), w_idx, 0);
        chk($sformatf("%s done dout", tag), w_dout, 0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ar0 = 1'b0; ar1 = 1'b0;
        mem0[0] = '0; mem0[1] = '0; mem1 = '0;
        tick(); tick(); tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk($sformatf("reset%0d dout", s), w_dout, 0);
            chk($sformatf("reset%0d busy", s), w_busy, 0);
            chk($sformatf("reset%0d done", s), w_done, 0);
            chk($sformatf("reset%0d pix_rd", s), w_rd, 0);
            chk($sformatf("reset%0d pix_idx", s), w_idx, 0);
        end
        sel = 1'b0;
        rst = 1'b0;
        tick();

        // 1: mixed pixels, single start
        mem0[0] = 24'hFF0000; mem0[1] = 24'h00000F;
        set_start(1); tick(); set_start(0);
        frame("t1", 24'hFF0000, 24'h00000F, 2, 0, 0);
        tick();
        chk("t1 after done busy", w_busy, 0);
        chk("t1 after done done", w_done, 0);

        // 2: all-zero pixels
        mem0[0] = 24'h000000; mem0[1] = 24'h000000;
        set_start(1); tick(); set_start(0);
        frame("t2", 24'h000000, 24'h000000, 2, 0, 0);
        tick();

        // 3: start hammered during the frame and in the done cycle
        mem0[0] = 24'hA55A3C; mem0[1] = 24'hC300FF;
        set_start(1); tick(); set_start(0);
        frame("t3", 24'hA55A3C, 24'hC300FF, 2, 0, 1);
        set_start(1); tick(); set_start(0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (w_busy || w_rd || w_done || w_dout) cnt++;
            tick();
        end
        chk("t3 no second frame", cnt, 0);

        // 4: auto-repeat with store updated between frames
        mem0[0] = 24'h123456; mem0[1] = 24'h789ABC;
        set_start(1); tick(); set_start(0);
        frame("t4a", 24'h123456, 24'h789ABC, 2, 1, 0);
        mem0[0] = 24'hFEDCBA; mem0[1] = 24'h0F0F0F;
        frame("t4b", 24'hFEDCBA, 24'h0F0F0F, 2, 0, 0);
        tick();
        chk("t4 end busy", w_busy, 0);

        // 5: reset in the middle of pixel 1, then a clean frame
        mem0[0] = 24'hFF0000; mem0[1] = 24'h00000F;
        set_start(1); tick(); set_start(0);
        for (int i = 0; i < 2 + 240 + 50; i++) tick();
        chk("t5 pre-reset dout", w_dout, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5 reset dout", w_dout, 0);
        chk("t5 reset busy", w_busy, 0);
        chk("t5 reset pix_rd", w_rd, 0);
        chk("t5 reset done", w_done, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (w_busy || w_dout || w_rd) cnt++;
        end
        chk("t5 stays idle", cnt, 0);
        set_start(1); tick(); set_start(0);
        frame("t5", 24'hFF0000, 24'h00000F, 2, 0, 0);
        tick();

        // 6: single-LED build
        sel = 1'b1;
        mem1 = 24'h5A0F3C;
        #0;
        set_start(1); tick(); set_start(0);
        frame("t6", 24'h5A0F3C, 24'h000000, 1, 0, 0);
        tick();
        chk("t6 after done busy", w_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ws2812_chain_tx.md
# ws2812_chain_tx

Parametrised serial transmitter for a chain of WS2812-class addressable LEDs. On `start` it fetches one 24-bit GRB word per LED from an upstream pixel store over a fixed-latency read port. It serialises each word MSB-first as a pulse-width-coded bit stream on `dout`, then holds the line low for the latch gap. It replaces the fixed 8-LED frame-counter/mux/shift/prescaler chain in the LED snake top with one block; optional auto-repeat gives continuous refresh.

## Interface
- `N_LEDS`, 8: LEDs in chain, ≥1
- `BIT_CYC`, 63: clk cycles per bit (1.25 µs @ 50 MHz)
- `T0H_CYC`, 20: high cycles for a 0 bit
- `T1H_CYC`, 40: high cycles for a 1 bit; 1 ≤ T0H_CYC < T1H_CYC < BIT_CYC
- `RESET_CYC`, 14000: low cycles of latch gap (280 µs), ≥1
- `IDX_W`, max(1, $clog2(N_LEDS)): pixel index width
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle request to send a frame; ignored while `busy`
- `auto_repeat` in 1: sampled at frame end; 1 = start next frame immediately
- `pix_rd` out 1: read strobe to pixel store
- `pix_idx` out IDX_W: LED index for `pix_rd`
- `pix_data` in 24: {G,R,B}, valid the cycle after `pix_rd`
- `dout` out 1: serial line to first LED
- `busy` out 1: frame in progress
- `done` out 1: one-cycle pulse at frame end

## Operation
- States: IDLE, FETCH, SEND, LATCH.
- IDLE: `dout`=0. `start`=1 → FETCH.
- FETCH, one cycle: `pix_rd`=1, `pix_idx`=0. Next cycle `pix_data` loads into the shift register, then → SEND.
- SEND: a bit counter runs 0..BIT_CYC-1. `dout`=1 while count < (bit ? T1H_CYC : T0H_CYC), else 0. Shift MSB-first; 24 bits per pixel.
- Prefetch: in the first cycle of pixel k (k < N_LEDS-1), `pix_rd`=1, `pix_idx`=k+1. The next cycle captures `pix_data` into a 24-bit hold register. At the pixel boundary the hold register loads into the shift register. No gap between pixels.
- After the last bit of pixel N_LEDS-1 → LATCH: `dout`=0 for RESET_CYC cycles.
- End of LATCH, one cycle: `done`=1.
  - `auto_repeat`=0: `busy`=0 and → IDLE.
  - `auto_repeat`=1: `busy` stays 1 and this cycle acts as FETCH (`pix_rd`=1, `pix_idx`=0).
- `start` during `busy` is dropped and not queued. `start` in the `done` cycle is ignored.
- `pix_data` is sampled only in the cycle after `pix_rd`.

## Timing
- Reset values, registered: `dout`=0, `busy`=0, `done`=0, `pix_rd`=0, `pix_idx`=0. State = IDLE; counters and shift/hold registers cleared.
- Reset mid-frame: next edge forces the reset values. A partial frame is not resumed.
- `start` high in cycle c0 (IDLE):
  - c1: `busy`=1, `pix_rd`=1, `pix_idx`=0.
  - c2: `pix_data` sampled.
  - c3: first bit begins, `dout` high.
- Bits occupy c3 .. c3+24·N_LEDS·BIT_CYC−1.
- LATCH fills the next RESET_CYC cycles.
- `done` occurs at cycle c3+24·N_LEDS·BIT_CYC+RESET_CYC.
- Bit counter width: $clog2(BIT_CYC). Latch counter width: $clog2(RESET_CYC+1). Pixel counter width: IDX_W. All counters wrap to 0 at terminal count; no overflow past terminal.
- N_LEDS=1: no prefetch strobe is issued.

## Structure
- `ws2812_pkg`:
  - state encoding (IDLE/FETCH/SEND/LATCH);
  - default timing constants for 50 MHz;
  - a `ws2812_timing_ok` check function used in an elaboration assertion on the parameters.
- One sub-module, `ws2812_bit_timer`: bit counter plus high/low comparator. Inputs: bit value, enable. Outputs: `level`, `bit_last`.
- Top holds the FSM, pixel/bit counters and the shift/hold registers.

## Test plan
Bench parameters: N_LEDS=2, BIT_CYC=10, T0H_CYC=3, T1H_CYC=7, RESET_CYC=20.

1. Store {0xFF0000, 0x00000F}, one `start` pulse. Required:
   - pix_rd idx0 at c1, idx1 at c3;
   - first 8 bits of `dout` are 7-high/3-low each;
   - total 480 bit cycles, 20 low cycles, then `done` at c3+500 and `busy` low the same cycle.
2. All-zero pixels. Every bit must be 3 high/7 low. No `dout` high during LATCH.
3. `start` pulsed repeatedly while `busy`. Exactly one frame is sent and one `done` pulse occurs.
4. `auto_repeat`=1, pixel store changed between frames. `busy` stays 1 across the boundary, pix_rd idx0 occurs in the `done` cycle, and the second frame carries the new data.
5. `rst` asserted mid-pixel-1. Next cycle `dout`=0, `busy`=0, state IDLE. A later `start` sends a full clean frame.
6. N_LEDS=1 build. Exactly one `pix_rd`, 24 bits, `done` at c3+260.
